// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcodes, functs, ALU control encoding, control FSM states
// and the datapath mux encodings driven by the multicycle sequencer.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOR  = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_SLTU = 3'b111
  } alu_ctl_t;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB   = 4'd7,
    IMMEX   = 4'd8,
    IMMWB   = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    SRCB_REG    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_BR_OFS = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps R-type funct or I-type opcode to the ALU operation and immediate extension mode.
// funct_legal flags whether an R-type funct is one the datapath supports.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       sgn_zero,
  output logic       funct_legal
);

  always_comb begin
    alu_control = ALU_ADD;
    sgn_zero    = 1'b0;
    funct_legal = 1'b0;
    if (op == OP_RTYPE) begin
      funct_legal = 1'b1;
      case (funct)
        FN_ADD, FN_ADDU: alu_control = ALU_ADD;
        FN_SUB, FN_SUBU: alu_control = ALU_SUB;
        FN_AND:          alu_control = ALU_AND;
        FN_OR:           alu_control = ALU_OR;
        FN_XOR:          alu_control = ALU_XOR;
        FN_NOR:          alu_control = ALU_NOR;
        FN_SLT:          alu_control = ALU_SLT;
        FN_SLTU:         alu_control = ALU_SLTU;
        default:         funct_legal = 1'b0;
      endcase
    end else begin
      // addiu/sltiu zero-extend here, as the datapath defines them
      case (op)
        OP_ANDI:  alu_control = ALU_AND;
        OP_ORI:   alu_control = ALU_OR;
        OP_XORI:  alu_control = ALU_XOR;
        OP_ADDI:  begin alu_control = ALU_ADD; sgn_zero = 1'b1; end
        OP_ADDIU: alu_control = ALU_ADD;
        OP_SLTI:  begin alu_control = ALU_SLT; sgn_zero = 1'b1; end
        OP_SLTIU: alu_control = ALU_SLTU;
        default:  alu_control = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer: drives datapath selects/enables per state,
// stalls FETCH/MEMRD/MEMWR on mem_ready.
//
// state   | meaning
// FETCH   | read instruction at PC, PC+4 when memory ready
// DECODE  | compute branch target, dispatch on op
// MEMADR  | base + sign-extended offset
// MEMRD   | load data read, wait for memory
// MEMWB   | load writeback to rt
// MEMWR   | store write, wait for memory
// RTYPEEX | R-type ALU op
// ALUWB   | R-type writeback to rd
// IMMEX   | I-type ALU op
// IMMWB   | I-type writeback to rt
// BRANCH  | compare, conditionally load branch target
// JUMP    | load jump target
module mc_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       sgn_zero,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal
);

  state_t     state, state_n;
  logic [2:0] dec_alu;
  logic       dec_sgn;
  logic       dec_funct_ok;

  alu_decoder u_alu_decoder (
    .op          (op),
    .funct       (funct),
    .alu_control (dec_alu),
    .sgn_zero    (dec_sgn),
    .funct_legal (dec_funct_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    mem_req     = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = PCSRC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_control = ALU_ADD;
    sgn_zero    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_n = DECODE;
      end
      DECODE: begin
        alu_src_b = SRCB_BR_OFS;
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE: begin
            if (dec_funct_ok) state_n = RTYPEEX;
            else begin
              illegal = 1'b1;
              state_n = FETCH;
            end
          end
          OP_ANDI, OP_ORI, OP_XORI, OP_ADDI,
          OP_ADDIU, OP_SLTI, OP_SLTIU: state_n = IMMEX;
          OP_BEQ, OP_BNE: state_n = BRANCH;
          OP_J:           state_n = JUMP;
          default: begin
            illegal = 1'b1;
            state_n = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        sgn_zero  = 1'b1;
        state_n   = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_n = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_n    = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_n = FETCH;
      end
      RTYPEEX: begin
        alu_src_a   = 1'b1;
        alu_control = dec_alu;
        state_n     = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_n   = FETCH;
      end
      IMMEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_alu;
        sgn_zero    = dec_sgn;
        state_n     = IMMWB;
      end
      IMMWB: begin
        reg_write = 1'b1;
        state_n   = FETCH;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = PCSRC_ALUOUT;
        pc_en       = (op == OP_BEQ) ? zero : ~zero;
        state_n     = FETCH;
      end
      JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_en   = 1'b1;
        state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
    // reset silences the datapath immediately, even mid memory access
    if (reset) begin
      mem_req     = 1'b0;
      iord        = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_en       = 1'b0;
      pc_src      = PCSRC_ALU;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_REG;
      alu_control = ALU_ADD;
      sgn_zero    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: instruction-level reference model of the
// per-cycle control word, driven with random ops, zero flags and memory waits.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, iord, mem_write, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_control;
  logic       sgn_zero, reg_dst, mem_to_reg, reg_write, illegal;

  int tests_run = 0;
  int tests_failed = 0;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .sgn_zero(sgn_zero),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, iord, mem_write, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       sgn_zero, reg_dst, mem_to_reg, reg_write, illegal;
  } ctl_t;

  ctl_t obs;
  assign obs = {mem_req, iord, mem_write, ir_write, pc_en, pc_src, alu_src_a,
                alu_src_b, alu_control, sgn_zero, reg_dst, mem_to_reg, reg_write, illegal};

  // Instruction phases as the programmer sees them
  typedef enum int {P_FETCH, P_DECODE, P_ADDR, P_LOAD, P_LOADWB, P_STORE,
                    P_REX, P_REXWB, P_IEX, P_IEXWB, P_BR, P_JMP} ph_t;

  // class: 0 illegal, 1 lw, 2 sw, 3 R-type, 4 I-type ALU, 5 branch, 6 jump
  function automatic int iclass(logic [5:0] o, logic [5:0] f);
    case (o)
      6'h23: return 1;
      6'h2B: return 2;
      6'h00: return ((f >= 6'h20 && f <= 6'h27) || f == 6'h2A || f == 6'h2B) ? 3 : 0;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: return 4;
      6'h04, 6'h05: return 5;
      6'h02: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int cpi(logic [5:0] o, logic [5:0] f);
    case (iclass(o, f))
      0: return 2;
      1: return 5;
      5, 6: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic ph_t phase_at(logic [5:0] o, logic [5:0] f, int i);
    int c;
    c = iclass(o, f);
    if (i == 0) return P_FETCH;
    if (i == 1) return P_DECODE;
    case (c)
      1: return (i == 2) ? P_ADDR : (i == 3) ? P_LOAD : P_LOADWB;
      2: return (i == 2) ? P_ADDR : P_STORE;
      3: return (i == 2) ? P_REX : P_REXWB;
      4: return (i == 2) ? P_IEX : P_IEXWB;
      5: return P_BR;
      default: return P_JMP;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] o, logic [5:0] f);
    if (o == 6'h00) begin
      case (f)
        6'h20, 6'h21: return 3'b000;
        6'h22, 6'h23: return 3'b001;
        6'h24: return 3'b010;
        6'h25: return 3'b011;
        6'h26: return 3'b100;
        6'h27: return 3'b101;
        6'h2A: return 3'b110;
        default: return 3'b111;
      endcase
    end
    case (o)
      6'h0C: return 3'b010;
      6'h0D: return 3'b011;
      6'h0E: return 3'b100;
      6'h0A: return 3'b110;
      6'h0B: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctl_t exp_out(ph_t p, logic [5:0] o, logic [5:0] f, logic z, logic rdy);
    ctl_t c;
    c = '0;
    case (p)
      P_FETCH:  begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_en = rdy; end
      P_DECODE: begin c.alu_src_b = 2'b11; c.illegal = (iclass(o, f) == 0); end
      P_ADDR:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.sgn_zero = 1; end
      P_LOAD:   begin c.mem_req = 1; c.iord = 1; end
      P_LOADWB: begin c.reg_write = 1; c.mem_to_reg = 1; end
      P_STORE:  begin c.mem_req = 1; c.iord = 1; c.mem_write = 1; end
      P_REX:    begin c.alu_src_a = 1; c.alu_control = alu_of(o, f); end
      P_REXWB:  begin c.reg_write = 1; c.reg_dst = 1; end
      P_IEX:    begin
        c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_control = alu_of(o, f);
        c.sgn_zero = (o == 6'h08 || o == 6'h0A);
      end
      P_IEXWB:  c.reg_write = 1;
      P_BR:     begin
        c.alu_src_a = 1; c.alu_control = 3'b001; c.pc_src = 2'b01;
        c.pc_en = (o == 6'h04) ? z : ~z;
      end
      default:  begin c.pc_src = 2'b10; c.pc_en = 1; end
    endcase
    return c;
  endfunction

  // Runs one whole instruction from FETCH; returns cycles taken
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int maxwait, output int cyc);
    ph_t  p;
    ctl_t e;
    int   waits;
    cyc = 0;
    for (int i = 0; i < cpi(o, f); i++) begin
      p = phase_at(o, f, i);
      waits = (p == P_FETCH || p == P_LOAD || p == P_STORE) && maxwait > 0 ?
              $urandom_range(0, maxwait) : 0;
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        op = o; funct = f; zero = z;
        if (p == P_FETCH || p == P_LOAD || p == P_STORE) mem_ready = (w == waits);
        else mem_ready = 1'($urandom_range(0, 1));
        #1;
        e = exp_out(p, o, f, z, mem_ready);
        tests_run++;
        if (obs !== e) begin
          tests_failed++;
          $display("FAIL instr op=%h funct=%h phase=%0d got=%h expected=%h", o, f, p, obs, e);
        end
        cyc++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1; op = 6'h23; funct = 0; zero = 1; mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 1'($urandom_range(0, 1)); #1;
      tests_run++;
      if (obs !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs got=%h expected=0", obs);
      end
    end
    @(negedge clk); reset = 0; mem_ready = 0; #1;
    tests_run++;
    if (obs !== exp_out(P_FETCH, op, funct, zero, 1'b0)) begin
      tests_failed++;
      $display("FAIL reset_release_fetch got=%h expected=%h", obs,
               exp_out(P_FETCH, op, funct, zero, 1'b0));
    end
  endtask

  task automatic test_lw;
    int cyc;
    run_instr(6'h23, 6'h00, 1'b0, 0, cyc);
    tests_run++;
    if (cyc !== 5) begin tests_failed++; $display("FAIL lw_cpi got=%0d expected=5", cyc); end
    run_instr(6'h2B, 6'h00, 1'b1, 0, cyc);
    tests_run++;
    if (cyc !== 4) begin tests_failed++; $display("FAIL sw_cpi got=%0d expected=4", cyc); end
  endtask

  task automatic test_fetch_stall;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); op = 6'h02; funct = 0; mem_ready = (i == 3); #1;
      tests_run++;
      if (i < 3 && (ir_write !== 0 || pc_en !== 0 || mem_req !== 1)) begin
        tests_failed++;
        $display("FAIL fetch_wait cyc=%0d got ir=%b pc=%b req=%b expected 0 0 1", i, ir_write, pc_en, mem_req);
      end else if (i == 3 && (ir_write !== 1 || pc_en !== 1)) begin
        tests_failed++;
        $display("FAIL fetch_ready got ir=%b pc=%b expected 1 1", ir_write, pc_en);
      end else if (i == 4 && (alu_src_b !== 2'b11 || mem_req !== 0)) begin
        tests_failed++;
        $display("FAIL fetch_to_decode got srcb=%b req=%b expected 11 0", alu_src_b, mem_req);
      end
    end
    @(negedge clk); #1;
    tests_run++;
    if (pc_en !== 1 || pc_src !== 2'b10) begin
      tests_failed++;
      $display("FAIL jump got pc_en=%b pc_src=%b expected 1 10", pc_en, pc_src);
    end
  endtask

  task automatic test_branch;
    int cyc;
    run_instr(6'h04, 6'h00, 1'b1, 1, cyc);
    run_instr(6'h05, 6'h00, 1'b1, 1, cyc);
    run_instr(6'h05, 6'h00, 1'b0, 0, cyc);
    tests_run++;
    if (cyc !== 3) begin tests_failed++; $display("FAIL branch_cpi got=%0d expected=3", cyc); end
  endtask

  task automatic test_imm;
    int cyc;
    run_instr(6'h0D, 6'h3F, 1'b0, 0, cyc);
    run_instr(6'h0A, 6'h00, 1'b0, 0, cyc);
    tests_run++;
    if (cyc !== 4) begin tests_failed++; $display("FAIL imm_cpi got=%0d expected=4", cyc); end
    run_instr(6'h00, 6'h2A, 1'b0, 2, cyc);
  endtask

  task automatic test_illegal;
    int cyc;
    run_instr(6'h3F, 6'h20, 1'b0, 0, cyc);
    tests_run++;
    if (cyc !== 2) begin tests_failed++; $display("FAIL illegal_cpi got=%0d expected=2", cyc); end
    run_instr(6'h00, 6'h00, 1'b0, 0, cyc);
    run_instr(6'h00, 6'h2C, 1'b1, 0, cyc);
  endtask

  task automatic test_reset_mid_write;
    ph_t seq [3] = '{P_FETCH, P_DECODE, P_ADDR};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); op = 6'h2B; funct = 0; zero = 0; mem_ready = 1; #1;
    end
    @(negedge clk); mem_ready = 0; #1;
    tests_run++;
    if (mem_write !== 1 || mem_req !== 1) begin
      tests_failed++;
      $display("FAIL store_wait got we=%b req=%b expected 1 1 after %0d phases", mem_write, mem_req, $size(seq));
    end
    @(negedge clk); reset = 1; #1;
    tests_run++;
    if (mem_write !== 0 || mem_req !== 0 || reg_write !== 0) begin
      tests_failed++;
      $display("FAIL reset_in_store got we=%b req=%b rw=%b expected 0 0 0", mem_write, mem_req, reg_write);
    end
    @(negedge clk); reset = 0; #1;
    tests_run++;
    if (obs !== exp_out(P_FETCH, op, funct, zero, 1'b0)) begin
      tests_failed++;
      $display("FAIL fetch_after_reset got=%h expected=%h", obs, exp_out(P_FETCH, op, funct, zero, 1'b0));
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] ops [14] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                             6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h3F};
    logic [5:0] o, f;
    int cyc;
    for (int n = 0; n < 60; n++) begin
      o = ops[$urandom_range(0, 13)];
      f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'h20 + 6'($urandom_range(0, 11));
      run_instr(o, f, 1'($urandom_range(0, 1)), 3, cyc);
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_fetch_stall;
    test_branch;
    test_imm;
    test_illegal;
    test_reset_mid_write;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
